// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared constants, types and lane helpers for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int          DMEM_AW_DEFAULT       = 11;
    localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'h0000_1FFC;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } acc_size_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } lane_t;

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] a);
        logic mis;
        case (sz)
            SZ_HALF: mis = a[0];
            SZ_WORD: mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Sub-word stores replicate the datum so every lane carries it; be picks the lane.
    function automatic lane_t store_lanes(input acc_size_e sz, input logic [1:0] a,
                                          input logic [31:0] wd);
        lane_t l;
        case (sz)
            SZ_BYTE: begin
                l.be   = 4'b0001 << a;
                l.data = {4{wd[7:0]}};
            end
            SZ_HALF: begin
                l.be   = 4'b0011 << {a[1], 1'b0};
                l.data = {2{wd[15:0]}};
            end
            SZ_WORD: begin
                l.be   = 4'b1111;
                l.data = wd;
            end
            default: begin
                l.be   = 4'b0000;
                l.data = wd;
            end
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : EX/MEM request and MEM/WB response bundle for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        wb_stall;
    logic        rsp_valid;
    logic [31:0] r_data;
    logic [31:0] r_addr;
    logic        is_load;
    logic [2:0]  load_val;
    logic [4:0]  rsp_rd;
    logic        misalign;
    logic [31:0] counter;

    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3, req_addr,
               req_wdata, req_rd, wb_stall,
        input  req_ready, rsp_valid, r_data, r_addr, is_load, load_val,
               rsp_rd, misalign, counter
    );

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3, req_addr,
               req_wdata, req_rd, wb_stall,
        output req_ready, rsp_valid, r_data, r_addr, is_load, load_val,
               rsp_rd, misalign, counter
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_dmem_bram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bram
// Description : Single-port 4x8-bit byte-lane data RAM, registered read with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bram #(
    parameter int AW = 11
) (
    input  wire logic          clk,
    input  wire logic [AW-1:0] addr,
    input  wire logic          re,
    input  wire logic [3:0]    we,
    input  wire logic [31:0]   din,
    output wire logic [31:0]   dout
);

    // One array per lane keeps each lane a plain 8-bit BSRAM with its own write enable.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] r_mem [0:(1<<AW)-1];
        logic [7:0] r_dout;

        always_ff @(posedge clk) begin
            if (we[i]) begin
                r_mem[addr] <= din[8*i +: 8];
            end
            if (re) begin
                r_dout <= r_mem[addr];
            end
        end

        assign dout[8*i +: 8] = r_dout;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : RV32I memory-access stage: store lanes, data RAM, MEM/WB register, cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEFAULT
) (
    input wire logic   clk,
    input wire logic   rst,
    mem_access_if.slave bus
);

    acc_size_e          w_size;
    lane_t              w_lanes;
    logic               w_accept;
    logic               w_is_mem;
    logic               w_misalign;
    logic               w_in_range;
    logic               w_cnt_hit;
    logic               w_store_ok;
    logic               w_cnt_we;
    logic               w_bram_re;
    logic [3:0]         w_bram_we;
    logic [DMEM_AW-1:0] w_word_idx;
    logic [31:0]        w_bram_dout;

    logic               r_rsp_valid;
    logic [31:0]        r_addr;
    logic               r_is_load;
    logic [2:0]         r_load_val;
    logic [4:0]         r_rd;
    logic               r_misalign;
    logic               r_data_zero;
    logic [31:0]        r_counter;

    assign bus.req_ready = !rst && !(r_rsp_valid && bus.wb_stall);
    assign w_accept      = bus.req_valid && bus.req_ready;

    assign w_size     = acc_size_e'(bus.req_funct3[1:0]);
    assign w_is_mem   = bus.req_is_load || bus.req_is_store;
    assign w_misalign = w_is_mem && is_misaligned(w_size, bus.req_addr[1:0]);
    assign w_lanes    = store_lanes(w_size, bus.req_addr[1:0], bus.req_wdata);
    assign w_in_range = (bus.req_addr[31:DMEM_AW+2] == '0);
    assign w_cnt_hit  = (bus.req_addr == HARDWARE_COUNTER_ADDR);
    assign w_word_idx = bus.req_addr[DMEM_AW+1:2];

    // The counter address shadows the RAM for stores only; loads still read the RAM.
    assign w_store_ok = w_accept && bus.req_is_store && !w_misalign;
    assign w_cnt_we   = w_store_ok && w_cnt_hit && (bus.req_funct3 == SW);
    assign w_bram_we  = (w_store_ok && w_in_range && !w_cnt_hit) ? w_lanes.be : 4'b0000;
    assign w_bram_re  = w_accept && bus.req_is_load && !w_misalign && w_in_range;

    dmem_bram #(
        .AW (DMEM_AW)
    ) u_dmem (
        .clk  (clk),
        .addr (w_word_idx),
        .re   (w_bram_re),
        .we   (w_bram_we),
        .din  (w_lanes.data),
        .dout (w_bram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_is_load   <= 1'b0;
            r_load_val  <= '0;
            r_rd        <= '0;
            r_misalign  <= 1'b0;
            r_data_zero <= 1'b1;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_addr      <= bus.req_addr;
            r_is_load   <= bus.req_is_load && !w_misalign;
            r_load_val  <= bus.req_funct3;
            r_rd        <= bus.req_rd;
            r_misalign  <= w_misalign;
            r_data_zero <= !w_bram_re;
        end else if (!bus.wb_stall) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter <= '0;
        end else if (w_cnt_we) begin
            r_counter <= bus.req_wdata;
        end else begin
            r_counter <= r_counter + 32'd1;
        end
    end

    // The RAM output register has no reset; masking keeps r_data at 0 after reset.
    assign bus.r_data    = r_data_zero ? 32'd0 : w_bram_dout;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.r_addr    = r_addr;
    assign bus.is_load   = r_is_load;
    assign bus.load_val  = r_load_val;
    assign bus.rsp_rd    = r_rd;
    assign bus.misalign  = r_misalign;
    assign bus.counter   = r_counter;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access with a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int AW        = 11;
    localparam int MEM_BYTES = 4 << AW;
    localparam logic [31:0] CNT_A = HARDWARE_COUNTER_ADDR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_if bus ();

    mem_access #(
        .DMEM_AW (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus the MEM/WB entry it implies.
    logic [7:0]  m_mem   [MEM_BYTES];
    bit          m_known [MEM_BYTES];
    bit          m_rsp_valid = 0;
    logic [31:0] m_addr = 0, m_data = 0, m_cnt = 0;
    logic [2:0]  m_f3 = 0;
    logic [4:0]  m_rd = 0;
    bit          m_is_load = 0, m_mis = 0, m_load_op = 0, m_data_known = 0;

    always @(posedge clk) begin
        bit          acc, mis, inr, hit;
        int          sz, ia, base;
        logic [31:0] a, nxt;
        a   = bus.req_addr;
        acc = bus.req_valid && !rst && !(m_rsp_valid && bus.wb_stall);
        nxt = m_cnt + 32'd1;
        if (rst) begin
            m_rsp_valid = 0; m_addr = 0; m_f3 = 0; m_rd = 0;
            m_is_load = 0; m_mis = 0; m_load_op = 0;
            nxt = 0;
        end else if (acc) begin
            sz  = 1 << bus.req_funct3[1:0];
            mis = (bus.req_is_load || bus.req_is_store) && ((a % sz) != 0);
            inr = a < MEM_BYTES;
            hit = (a == CNT_A);
            ia  = int'(a[AW+1:0]);
            if (bus.req_is_store && !mis) begin
                if (hit) begin
                    if (sz == 4) nxt = bus.req_wdata;
                end else if (inr) begin
                    for (int b = 0; b < sz; b++) begin
                        m_mem[ia+b]   = bus.req_wdata[8*b +: 8];
                        m_known[ia+b] = 1;
                    end
                end
            end
            m_rsp_valid = 1;
            m_addr      = a;
            m_f3        = bus.req_funct3;
            m_rd        = bus.req_rd;
            m_mis       = mis;
            m_is_load   = bus.req_is_load && !mis;
            m_load_op   = bus.req_is_load;
            if (bus.req_is_load && !mis && inr) begin
                base         = ia & ~3;
                m_data       = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
                m_data_known = m_known[base] && m_known[base+1] && m_known[base+2] && m_known[base+3];
            end else begin
                m_data       = 32'd0;
                m_data_known = 1;
            end
        end else if (!bus.wb_stall) begin
            m_rsp_valid = 0;
        end
        m_cnt = nxt;
    end

    always @(negedge clk) begin
        chk("req_ready", bus.req_ready, !rst && !(m_rsp_valid && bus.wb_stall));
        chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
        chk("counter",   bus.counter,   m_cnt);
        if (m_rsp_valid) begin
            chk("r_addr",   bus.r_addr,   m_addr);
            chk("is_load",  bus.is_load,  m_is_load);
            chk("load_val", bus.load_val, m_f3);
            chk("rsp_rd",   bus.rsp_rd,   m_rd);
            chk("misalign", bus.misalign, m_mis);
            if (m_load_op && m_data_known) chk("r_data", bus.r_data, m_data);
        end
    end

    task automatic idle();
        bus.req_valid    = 1'b0;
        bus.req_is_load  = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rd       = 5'd0;
    endtask

    task automatic set_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = ld;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
    endtask

    // Presents one op for one edge; on return the MEM/WB result is visible.
    task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        set_op(ld, st, f3, a, wd, rd);
        @(posedge clk); #2;
        idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " r_data"},    bus.r_data,    0);
        chk({tag, " r_addr"},    bus.r_addr,    0);
        chk({tag, " is_load"},   bus.is_load,   0);
        chk({tag, " load_val"},  bus.load_val,  0);
        chk({tag, " rsp_rd"},    bus.rsp_rd,    0);
        chk({tag, " misalign"},  bus.misalign,  0);
        chk({tag, " counter"},   bus.counter,   0);
    endtask

    initial begin
        idle();
        bus.wb_stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        chk("reset req_ready", bus.req_ready, 0);
        rst = 1'b0;

        op(0, 1, SW, 32'h10, 32'h0, 0);
        op(0, 1, SW, 32'h20, 32'h0, 0);
        op(0, 1, SW, 32'h30, 32'h0, 0);

        // SB into a word
        op(0, 1, SW, 32'h10, 32'h1122_3344, 0);
        op(0, 1, SB, 32'h12, 32'h0000_00AA, 0);
        op(1, 0, LW, 32'h10, 32'h0, 5'd5);
        chk("sb r_data", bus.r_data, 32'h11AA_3344);
        chk("sb rsp_valid", bus.rsp_valid, 1);
        chk("sb rsp_rd", bus.rsp_rd, 5);

        // SH upper half, then a misaligned SH that must not land
        op(0, 1, SH, 32'h22, 32'h0000_BEEF, 0);
        op(0, 1, SH, 32'h23, 32'h0000_1234, 0);
        chk("sh23 misalign", bus.misalign, 1);
        op(1, 0, LW, 32'h20, 32'h0, 5'd6);
        chk("sh r_data", bus.r_data, 32'hBEEF_0000);

        // Misaligned word load, then aligned halfword load on the upper half
        op(1, 0, LW, 32'h21, 32'h0, 5'd1);
        chk("mis misalign", bus.misalign, 1);
        chk("mis is_load", bus.is_load, 0);
        chk("mis r_data", bus.r_data, 0);
        op(1, 0, LH, 32'h22, 32'h0, 5'd2);
        chk("lh misalign", bus.misalign, 0);
        chk("lh r_data", bus.r_data, 32'hBEEF_0000);
        chk("lh load_val", bus.load_val, 32'(LH));

        // Out of range: store dropped, load reads zero, no aliasing onto 0x10
        op(0, 1, SW, 32'h4000_0010, 32'hCAFE_F00D, 0);
        op(1, 0, LW, 32'h4000_0010, 32'h0, 5'd4);
        chk("oor r_data", bus.r_data, 0);
        chk("oor is_load", bus.is_load, 1);
        op(1, 0, LW, 32'h10, 32'h0, 5'd4);
        chk("oor alias", bus.r_data, 32'h11AA_3344);

        // Stall: outputs freeze, held request goes in once the stall drops
        op(1, 0, LW, 32'h10, 32'h0, 5'd3);
        set_op(1, 0, LW, 32'h20, 32'h0, 5'd7);
        bus.wb_stall = 1'b1;
        #1;
        chk("stall req_ready", bus.req_ready, 0);
        repeat (2) begin
            @(posedge clk); #2;
            chk("stall r_data", bus.r_data, 32'h11AA_3344);
            chk("stall rsp_rd", bus.rsp_rd, 3);
            chk("stall req_ready", bus.req_ready, 0);
        end
        @(posedge clk); #2;
        chk("stall3 r_data", bus.r_data, 32'h11AA_3344);
        bus.wb_stall = 1'b0;
        #1;
        chk("unstall req_ready", bus.req_ready, 1);
        @(posedge clk); #2;
        idle();
        chk("unstall rsp_rd", bus.rsp_rd, 7);
        chk("unstall r_data", bus.r_data, 32'hBEEF_0000);

        // Counter write, count, loads at the counter address, dropped SB, wrap
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        op(0, 1, SW, CNT_A, 32'h0000_0100, 0);
        chk("cnt wr", bus.counter, 32'h100);
        @(posedge clk); #2;
        chk("cnt +1", bus.counter, 32'h101);
        op(1, 0, LW, CNT_A, 32'h0, 5'd8);
        chk("cnt lw is_load", bus.is_load, 1);
        op(1, 0, LW, CNT_A, 32'h0, 5'd9);
        chk("cnt lw2", bus.counter, 32'h103);
        op(0, 1, SB, CNT_A, 32'h0000_0055, 0);
        chk("cnt sb drop", bus.counter, 32'h104);
        op(0, 1, SW, CNT_A, 32'hFFFF_FFFF, 0);
        chk("cnt max", bus.counter, 32'hFFFF_FFFF);
        @(posedge clk); #2;
        chk("cnt wrap", bus.counter, 32'h0);

        // Reset coincident with a store request
        set_op(0, 1, SW, 32'h30, 32'hDEAD_BEEF, 0);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        idle();
        chk_all_zero("rst mid");
        op(1, 0, LW, 32'h30, 32'h0, 5'd10);
        chk("rst mid mem", bus.r_data, 0);

        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
